seven_seg_reader: RTL and testbench
===================================

SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, consecutive identical samples required before a digit commits (legal range 2..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 seg  input  7  active-low segment pattern from the display bus, seg[0]=a .. seg[6]=g.
REQ-005 an  input  4  active-low digit enables; an[i]=0 selects digit i.
REQ-006 digits  output  16  last complete frame, BCD, digit i in bits [4i+3:4i].
REQ-007 blank  output  4  blank[i]=1 when digit i was blank in the last complete frame.
REQ-008 frame_valid  output  1  one-cycle pulse when digits/blank/frame_err update.
REQ-009 frame_err  output  1  last complete frame contained at least one unrecognised pattern.
REQ-010 bad_pattern  output  1  one-cycle pulse when a committed pattern is unrecognised.

Function
REQ-011 Decode table (seg, hex) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F; any other value is unrecognised.
REQ-012 A sample SHALL be "selected" when exactly one bit of an is 0; the sample pair is {an, seg}.
REQ-013 FSM states SHALL be WAIT, SETTLE, HELD.
REQ-014 WAIT: no selected sample; selected sample -> SETTLE, stability count = 1, pair stored.
REQ-015 SETTLE: pair equal to stored -> count+1; pair differs but selected -> restart count at 1 with new pair; not selected -> WAIT, count 0.
REQ-016 Commit SHALL occur on the edge at which count reaches STABLE_CYCLES; FSM -> HELD on that edge.
REQ-017 HELD: pair unchanged -> stay, no further commit; pair changes and selected -> SETTLE (count 1); not selected -> WAIT.
REQ-018 Commit of digit i SHALL write the decoded BCD into working slot i (4'hF if blank or unrecognised), set working blank bit i per blank, set working error bit i if unrecognised, and set seen-mask bit i.
REQ-019 Re-commit of a digit already seen in the current frame SHALL overwrite its working slot, blank and error bits.
REQ-020 bad_pattern SHALL be high for exactly the cycle following an unrecognised commit.
REQ-021 When a commit makes seen-mask 4'b1111, on that same edge digits/blank SHALL load the working values (including this commit), frame_err SHALL load OR of working error bits, frame_valid SHALL assert for one cycle, and seen-mask and working error bits SHALL clear.
REQ-022 Latency: pair stable before edges k..k+STABLE_CYCLES-1 -> commit, and frame_valid if completing, visible after edge k+STABLE_CYCLES-1.
REQ-023 Zero or multiple anodes low SHALL never commit and SHALL NOT clear seen-mask.
REQ-024 Stability counter SHALL saturate at STABLE_CYCLES; no wrap.
REQ-025 digits, blank, frame_err SHALL hold between frame_valid pulses.

Reset
REQ-026 On rst=1 at a rising edge: FSM=WAIT, count=0, stored pair cleared, seen-mask=0, working slots=4'hF, digits=16'hFFFF, blank=4'hF, frame_err=0, frame_valid=0, bad_pattern=0.
REQ-027 rst asserted mid-SETTLE or mid-frame SHALL discard partial frame; rst takes priority over any commit on the same edge.

Verification
REQ-028 STABLE_CYCLES=4; drive an=1110/seg=30, an=1101/seg=24, an=1011/seg=79, an=0111/seg=40, each 4 cycles -> single frame_valid after 16th edge, digits=16'h0123, blank=0, frame_err=0.
REQ-029 Pair held 3 cycles then changed -> no commit, seen-mask unchanged; same pair held 20 cycles -> exactly one commit.
REQ-030 Frame with digit 2 seg=7F -> blank=4'b0100, digits[11:8]=F, frame_err=0; digit 1 seg=55 -> bad_pattern one pulse, frame_err=1 on frame_valid.
REQ-031 an=1100 or an=1111 held 10 cycles between digits -> no commit, prior seen bits kept, frame still completes on 4th distinct digit.
REQ-032 rst pulsed after 3 digits committed -> outputs at reset values; 4th digit alone produces no frame_valid.
REQ-033 Digit 0 committed twice (seg=79 then 19) before frame complete -> digits[3:0]=4.

Source files
------------

// File: rtl/seven_seg_reader.sv
// seven_seg_reader: watches a multiplexed, active-low seven-segment display
// bus and rebuilds the four BCD digits it shows. A digit commits once the
// same {an, seg} pair has been seen on STABLE_CYCLES consecutive clocks. A
// frame is published once all four digit positions have committed.
//
// Handshake: frame_valid and bad_pattern are single-cycle strobes with no
// ready/backpressure. digits, blank and frame_err are only meaningful on the
// frame_valid cycle, and they hold their value until the next frame_valid.
module seven_seg_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        bad_pattern
);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  // Sampler state. The FSM state register is named "state" so checkers can
  // bind to it directly.
  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [10:0] pair_q, pair_nxt;
  logic [10:0] pair;
  logic        commit;

  // Frame assembly state.
  logic [15:0] work_digits, work_digits_upd;
  logic [3:0]  work_blank, work_blank_upd;
  logic [3:0]  work_err, work_err_upd;
  logic [3:0]  seen, seen_upd;

  // Anode decode results.
  logic        selected;
  logic [1:0]  sel_idx;

  // Pattern decode results.
  logic        pat_known;
  logic        pat_blank;
  logic [3:0]  pat_bcd;

  assign pair = {an, seg};

  // Identify a sample with exactly one anode driven low, and which digit it is.
  always_comb begin
    selected = 1'b1;
    sel_idx  = 2'd0;
    case (an)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: selected = 1'b0;
    endcase
  end

  // Translate the active-low segment pattern into BCD, blank or unknown.
  always_comb begin
    pat_known = 1'b1;
    pat_blank = 1'b0;
    pat_bcd   = 4'hF;
    case (seg)
      7'h40: pat_bcd = 4'd0;
      7'h79: pat_bcd = 4'd1;
      7'h24: pat_bcd = 4'd2;
      7'h30: pat_bcd = 4'd3;
      7'h19: pat_bcd = 4'd4;
      7'h12: pat_bcd = 4'd5;
      7'h02: pat_bcd = 4'd6;
      7'h78: pat_bcd = 4'd7;
      7'h00: pat_bcd = 4'd8;
      7'h10: pat_bcd = 4'd9;
      7'h7F: pat_blank = 1'b1;
      default: pat_known = 1'b0;
    endcase
  end

  // Sampler FSM state, stability count and stored pair registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= WAIT;
      count  <= 4'd0;
      pair_q <= 11'd0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      pair_q <= pair_nxt;
    end
  end

  // Sampler next-state logic. The count saturates at STABLE_N while HELD, so a
  // long steady pair commits only once.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pair_nxt  = pair_q;
    commit    = 1'b0;
    case (state)
      WAIT: begin
        if (selected) begin
          state_nxt = SETTLE;
          count_nxt = 4'd1;
          pair_nxt  = pair;
        end
      end
      SETTLE: begin
        if (!selected) begin
          state_nxt = WAIT;
          count_nxt = 4'd0;
        end else if (pair == pair_q) begin
          if (count >= STABLE_N - 4'd1) begin
            count_nxt = STABLE_N;
            commit    = 1'b1;
            state_nxt = HELD;
          end else begin
            count_nxt = count + 4'd1;
          end
        end else begin
          count_nxt = 4'd1;
          pair_nxt  = pair;
        end
      end
      HELD: begin
        if (pair != pair_q) begin
          if (selected) begin
            state_nxt = SETTLE;
            count_nxt = 4'd1;
            pair_nxt  = pair;
          end else begin
            state_nxt = WAIT;
            count_nxt = 4'd0;
          end
        end
      end
      default: begin
        state_nxt = WAIT;
        count_nxt = 4'd0;
      end
    endcase
  end

  // Working frame contents as they would look after the current commit.
  always_comb begin
    work_digits_upd = work_digits;
    work_blank_upd  = work_blank;
    work_err_upd    = work_err;
    seen_upd        = seen;
    if (commit) begin
      work_digits_upd[4*sel_idx +: 4] = pat_bcd;
      work_blank_upd[sel_idx]         = pat_blank;
      work_err_upd[sel_idx]           = ~pat_known;
      seen_upd[sel_idx]               = 1'b1;
    end
  end

  // Frame assembly: record commits, and publish the frame when all four
  // digit positions have committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_digits <= 16'hFFFF;
      work_blank  <= 4'hF;
      work_err    <= 4'h0;
      seen        <= 4'h0;
      digits      <= 16'hFFFF;
      blank       <= 4'hF;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
      if (commit) begin
        work_digits <= work_digits_upd;
        work_blank  <= work_blank_upd;
        bad_pattern <= ~pat_known;
        if (seen_upd == 4'hF) begin
          digits      <= work_digits_upd;
          blank       <= work_blank_upd;
          frame_err   <= |work_err_upd;
          frame_valid <= 1'b1;
          seen        <= 4'h0;
          work_err    <= 4'h0;
        end else begin
          seen     <= seen_upd;
          work_err <= work_err_upd;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Testbench for seven_seg_reader: directed digit sequences with hand-computed
// frames pushed to a scoreboard queue, checked by an independent monitor.
module tb_seven_seg_reader;

  logic        clk;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        frame_err;
  logic        bad_pattern;

  // Expected frame = {frame_err, blank, digits}.
  logic [20:0] exp_q[$];
  int          n_cmp;
  int          n_bad;
  int          bad_pulses;
  logic        bad_prev;

  seven_seg_reader #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .blank       (blank),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .bad_pattern (bad_pattern)
  );

  // Clock and reset-time defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic comparison helper.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Driver: present one {an, seg} pair for n clock edges.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  // Driver: one full digit commit (4 stable cycles).
  task automatic digit(input int idx, input logic [6:0] s);
    logic [3:0] a;
    a = 4'hF;
    a[idx] = 1'b0;
    drive(a, s, 4);
  endtask

  task automatic expect_frame(input logic err, input logic [3:0] b, input logic [15:0] d);
    exp_q.push_back({err, b, d});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0000FFFF);
    check({tag, "_blank"}, 32'(blank), 32'hF);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_frame_valid"}, 32'(frame_valid), 32'h0);
    check({tag, "_bad_pattern"}, 32'(bad_pattern), 32'h0);
  endtask

  // Monitor: compare every published frame against the scoreboard, and
  // watch bad_pattern for single-cycle pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: got %h/%h/%b, expected no frame", digits, blank, frame_err);
        end else begin
          logic [20:0] e;
          e = exp_q.pop_front();
          check("frame_digits", 32'(digits), 32'(e[15:0]));
          check("frame_blank", 32'(blank), 32'(e[19:16]));
          check("frame_err", 32'(frame_err), 32'(e[20]));
        end
      end
      if (bad_pattern) begin
        bad_pulses++;
        if (bad_prev) begin
          n_cmp++;
          n_bad++;
          $display("FAIL bad_pattern_width: got 2+ cycles, expected 1");
        end
      end
      bad_prev = bad_pattern;
    end else begin
      bad_prev = 1'b0;
    end
  end

  // Stimulus.
  initial begin
    n_cmp = 0;
    n_bad = 0;
    bad_pulses = 0;
    bad_prev = 1'b0;
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic frame: digits 3,2,1,0 on positions 0..3.
    expect_frame(1'b0, 4'h0, 16'h0123);
    digit(0, 7'h30);
    digit(1, 7'h24);
    digit(2, 7'h79);
    digit(3, 7'h40);

    // 3-cycle glitch must not commit; 20-cycle hold commits once.
    expect_frame(1'b0, 4'h0, 16'h2341);
    drive(4'b1110, 7'h12, 3);
    drive(4'b1101, 7'h19, 20);
    digit(2, 7'h30);
    digit(3, 7'h24);
    digit(0, 7'h79);

    // Blank digit 2.
    expect_frame(1'b0, 4'b0100, 16'h8F76);
    digit(0, 7'h02);
    digit(1, 7'h78);
    digit(2, 7'h7F);
    digit(3, 7'h00);

    // Unrecognised pattern on digit 1.
    expect_frame(1'b1, 4'h0, 16'h50F9);
    digit(0, 7'h10);
    digit(1, 7'h55);
    digit(2, 7'h40);
    digit(3, 7'h12);

    // Zero / multiple anodes between digits keep seen bits.
    expect_frame(1'b0, 4'h0, 16'h7423);
    digit(0, 7'h30);
    drive(4'b1100, 7'h24, 10);
    digit(1, 7'h24);
    drive(4'b1111, 7'h79, 10);
    digit(2, 7'h19);
    digit(3, 7'h78);

    // Reset after three digits discards the partial frame.
    digit(0, 7'h40);
    digit(1, 7'h79);
    digit(2, 7'h24);
    rst = 1'b1;
    an  = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midreset");
    digit(3, 7'h10);
    drive(4'hF, 7'h7F, 3);
    check("after_lone_digit_digits", 32'(digits), 32'h0000FFFF);
    expect_frame(1'b0, 4'h0, 16'h9653);
    digit(0, 7'h30);
    digit(1, 7'h12);
    digit(2, 7'h02);

    // Digit 0 re-committed before frame completes.
    expect_frame(1'b0, 4'h0, 16'h0004);
    digit(0, 7'h79);
    digit(0, 7'h19);
    digit(1, 7'h40);
    digit(2, 7'h40);
    digit(3, 7'h40);

    // Outputs hold between frames; everything expected was seen.
    drive(4'hF, 7'h7F, 10);
    check("hold_digits", 32'(digits), 32'h00000004);
    check("hold_blank", 32'(blank), 32'h0);
    check("hold_frame_err", 32'(frame_err), 32'h0);
    check("frames_outstanding", 32'(exp_q.size()), 32'h0);
    check("bad_pattern_pulses", 32'(bad_pulses), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
